// File: rtl/seven_segment_scanner_if.sv
// Bus bundle between the register block and the 4-digit scanner:
// display value and controls flow in, anode/cathode drives flow out.
interface seven_segment_scanner_if;
  logic [15:0] VALUE;
  logic [3:0]  DP_MASK;
  logic        LZS;
  logic        ENABLE;
  logic [3:0]  SEG_SELECT;
  logic [7:0]  LED;

  modport master (
    output VALUE, DP_MASK, LZS, ENABLE,
    input  SEG_SELECT, LED
  );

  modport slave (
    input  VALUE, DP_MASK, LZS, ENABLE,
    output SEG_SELECT, LED
  );
endinterface

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed 4-digit common-anode driver. A prescaler sets the digit
// slot length; each slot opens with an all-off blank window to stop ghosting.
// The value is latched once per full scan so a frame never mixes two writes.
module seven_segment_scanner #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic CLK,
  input  logic RESET,
  seven_segment_scanner_if.slave bus
);
  localparam int CW = $clog2(REFRESH_DIV);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [15:0]   r_val;
  logic [3:0]    r_dp;
  logic          r_lzs;
  logic          r_first;
  logic [3:0]    r_seg;
  logic [7:0]    r_led;

  logic          w_tc;
  logic          w_cap;
  logic          w_blank;
  logic [3:0]    w_nib;
  logic          w_lz;
  logic [6:0]    w_hex;

  // active-low {g,f,e,d,c,b,a} pattern for one hex nibble
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  assign w_tc    = (r_cnt == CW'(REFRESH_DIV - 1));
  // first edge after reset, or the edge that wraps digit 3 back to digit 0
  assign w_cap   = r_first || (w_tc && (r_idx == 2'd3));
  assign w_blank = (r_cnt < CW'(BLANK_CYCLES));
  assign w_nib   = r_val[r_idx*4 +: 4];
  assign w_hex   = hex7(w_nib);

  // leading zero: this digit and every digit to its left are zero
  always_comb begin
    w_lz = 1'b0;
    case (r_idx)
      2'd1:    w_lz = (r_val[15:4]  == 12'h000);
      2'd2:    w_lz = (r_val[15:8]  == 8'h00);
      2'd3:    w_lz = (r_val[15:12] == 4'h0);
      default: w_lz = 1'b0;
    endcase
  end

  // slot prescaler and digit index
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (w_tc) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // per-scan snapshot of value, decimal points and suppression mode
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_val   <= 16'h0000;
      r_dp    <= 4'h0;
      r_lzs   <= 1'b0;
      r_first <= 1'b1;
    end else begin
      r_first <= 1'b0;
      if (w_cap) begin
        r_val <= bus.VALUE;
        r_dp  <= bus.DP_MASK;
        r_lzs <= bus.LZS;
      end
    end
  end

  // registered anode/cathode drive; blanked by window or disable
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_seg <= 4'hF;
      r_led <= 8'hFF;
    end else if (!bus.ENABLE || w_blank) begin
      r_seg <= 4'hF;
      r_led <= 8'hFF;
    end else begin
      r_seg <= ~(4'b0001 << r_idx);
      r_led <= {~r_dp[r_idx], (r_lzs && w_lz) ? 7'h7F : w_hex};
    end
  end

  assign bus.SEG_SELECT = r_seg;
  assign bus.LED        = r_led;
endmodule

// File: tb/tb_seven_segment_scanner.sv
// Scoreboard bench: expected drive is pushed before each edge from a
// position-based reference and popped/compared 1 ns after the edge.
module tb_seven_segment_scanner;
  localparam int RD = 8;
  localparam int BL = 2;
  localparam int SCAN = 4 * RD;

  typedef struct {
    logic [3:0] seg;
    logic [7:0] led;
  } exp_t;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  seven_segment_scanner_if bus();

  seven_segment_scanner #(.REFRESH_DIV(RD), .BLANK_CYCLES(BL)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  exp_t q[$];
  int n_vec = 0;
  int n_err = 0;

  // reference state: cycles since reset release plus the latched frame
  int         m_pos;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic        m_lzs;
  logic        m_first;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    int cnt, idx;
    logic [15:0] above;
    logic [6:0] s7;
    cnt = m_pos % RD;
    idx = (m_pos / RD) % 4;
    e.seg = 4'hF;
    e.led = 8'hFF;
    if (bus.ENABLE && cnt >= BL) begin
      above = m_val >> (4 * idx);
      s7 = (m_lzs && idx != 0 && above == 16'h0) ? 7'h7F : HEX[above[3:0]];
      e.seg = 4'hF & ~(4'b0001 << idx);
      e.led = {~m_dp[idx], s7};
    end
    return e;
  endfunction

  task automatic model_step();
    if (m_first || (m_pos % SCAN) == SCAN - 1) begin
      m_val = bus.VALUE;
      m_dp  = bus.DP_MASK;
      m_lzs = bus.LZS;
    end
    m_first = 1'b0;
    m_pos++;
  endtask

  task automatic tick();
    exp_t e;
    q.push_back(model_out());
    model_step();
    @(posedge CLK);
    #1;
    e = q.pop_front();
    chk("seg", {4'h0, bus.SEG_SELECT}, {4'h0, e.seg});
    chk("led", bus.LED, e.led);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // async assert between edges, hold two edges, release away from the edge
  task automatic do_reset();
    #2;
    RESET = 1'b0;
    #1;
    chk("rst_async_seg", {4'h0, bus.SEG_SELECT}, 8'h0F);
    chk("rst_async_led", bus.LED, 8'hFF);
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK);
      #1;
      chk("rst_hold_seg", {4'h0, bus.SEG_SELECT}, 8'h0F);
      chk("rst_hold_led", bus.LED, 8'hFF);
    end
    RESET   = 1'b1;
    m_pos   = 0;
    m_val   = 16'h0;
    m_dp    = 4'h0;
    m_lzs   = 1'b0;
    m_first = 1'b1;
  endtask

  task automatic run_to(input int slot_pos);
    while ((m_pos % SCAN) != slot_pos) tick();
  endtask

  initial begin
    bus.VALUE   = 16'h1234;
    bus.DP_MASK = 4'h0;
    bus.LZS     = 1'b0;
    bus.ENABLE  = 1'b1;
    @(posedge CLK);
    #1;
    do_reset();

    // scan order, then a write during the digit 1 slot
    ticks(2 * SCAN);
    run_to(RD + 3);
    bus.VALUE = 16'h8888;
    ticks(2 * SCAN);

    // leading-zero suppression patterns
    bus.LZS = 1'b1;
    foreach (HEX[k]) begin end
    bus.VALUE = 16'h0050; ticks(2 * SCAN);
    bus.VALUE = 16'h0000; ticks(2 * SCAN);
    bus.VALUE = 16'h0100; ticks(2 * SCAN);
    bus.VALUE = 16'h0005; ticks(2 * SCAN);
    bus.LZS = 1'b0;
    bus.VALUE = 16'h0000; ticks(2 * SCAN);

    // decimal point on digit 2 only
    bus.DP_MASK = 4'b0100;
    bus.VALUE   = 16'hFFFF;
    ticks(2 * SCAN);

    // disable mid-slot, re-enable without restart
    run_to(2 * RD + 4);
    bus.ENABLE = 1'b0;
    ticks(20);
    bus.ENABLE = 1'b1;
    ticks(SCAN + 8);

    // mixed digits and dp, then reset mid-scan with a fresh value
    bus.DP_MASK = 4'b1001;
    bus.VALUE   = 16'hA5C3;
    ticks(SCAN + 13);
    bus.VALUE   = 16'h9E7B;
    bus.DP_MASK = 4'b0010;
    do_reset();
    ticks(2 * SCAN);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
